// File: rtl/dmem_responder.sv
// Data-memory responder: loads, byte-masked stores and add/swap AMOs on a single-port 64-bit array.
// Responses arrive LATENCY cycles after the fire edge with no back-pressure; an AMO drops req_rdy for one cycle.
module dmem_responder #(
  parameter int WORDS_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req_val,
  output logic        dmem_req_rdy,
  input  logic [3:0]  dmem_req_op,
  input  logic [31:0] dmem_req_addr,
  input  logic [63:0] dmem_req_data,
  input  logic [7:0]  dmem_req_wmask,
  input  logic [11:0] dmem_req_tag,
  output logic        dmem_resp_val,
  output logic [63:0] dmem_resp_data,
  output logic [11:0] dmem_resp_tag
);

  localparam int DEPTH = 1 << WORDS_LOG2;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SWAP  = 4'b0101;

  typedef enum logic {IDLE, AMO_WR} state_t;

  logic [63:0]           mem [DEPTH];
  state_t                state;
  logic [WORDS_LOG2-1:0] idx;
  logic                  fire;
  logic                  is_load;
  logic                  is_store;
  logic                  is_amo;

  logic [WORDS_LOG2-1:0] amo_idx;
  logic                  amo_is_add;
  logic [63:0]           amo_old;
  logic [63:0]           amo_data;
  logic [7:0]            amo_wmask;

  logic                  wr_en;
  logic [WORDS_LOG2-1:0] wr_idx;
  logic [63:0]           wr_data;
  logic [7:0]            wr_mask;

  logic                  pipe_val [LATENCY];
  logic [11:0]           pipe_tag [LATENCY];
  logic [63:0]           pipe_dat [LATENCY];

  logic                  unused_addr_bits;

  assign idx      = dmem_req_addr[WORDS_LOG2+2:3];
  assign is_load  = (dmem_req_op == OP_LOAD);
  assign is_store = (dmem_req_op == OP_STORE);
  assign is_amo   = (dmem_req_op == OP_ADD) || (dmem_req_op == OP_SWAP);
  // rdy is registered and may read 1 during reset, so reset must also veto the fire
  assign fire     = dmem_req_val && dmem_req_rdy && !reset;

  assign unused_addr_bits = ^{dmem_req_addr[31:WORDS_LOG2+3], dmem_req_addr[2:0]};

  // The single write port is shared: stores in IDLE, the deferred AMO write-back in AMO_WR.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = dmem_req_data;
    wr_mask = dmem_req_wmask;
    if (state == AMO_WR) begin
      wr_en   = !reset;
      wr_idx  = amo_idx;
      wr_data = amo_is_add ? (amo_old + amo_data) : amo_data;
      wr_mask = amo_wmask;
    end else begin
      wr_en = fire && is_store;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dmem_req_rdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fire && is_amo) begin
            state        <= AMO_WR;
            dmem_req_rdy <= 1'b0;
            amo_idx      <= idx;
            amo_old      <= mem[idx];
            amo_data     <= dmem_req_data;
            amo_wmask    <= dmem_req_wmask;
            amo_is_add   <= (dmem_req_op == OP_ADD);
          end
        end
        AMO_WR: begin
          state        <= IDLE;
          dmem_req_rdy <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          dmem_req_rdy <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_val[i] <= 1'b0;
    end else begin
      pipe_val[0] <= fire && (is_load || is_amo);
      for (int i = 1; i < LATENCY; i++) pipe_val[i] <= pipe_val[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= dmem_req_tag;
    pipe_dat[0] <= mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  assign dmem_resp_val  = pipe_val[LATENCY-1];
  assign dmem_resp_tag  = pipe_tag[LATENCY-1];
  assign dmem_resp_data = pipe_dat[LATENCY-1];

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's dmem request/response interface: accepts requests on dmem_req_*, returns tagged load/AMO data on dmem_resp_*.
- Backed by a single-port 64-bit-wide synchronous array.
- Used as the data-memory model behind a core in simulation and small FPGA builds.
- Serves loads, byte-masked stores, and two AMOs (add, swap) with fixed response latency.

Parameters:
- WORDS_LOG2, 12, log2 of array depth in 64-bit doublewords (32 KiB default).
- LATENCY, 2, cycles from request acceptance edge to dmem_resp_val; legal range 1..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dmem_req_val  in  1  request valid
- dmem_req_rdy  out  1  responder can accept; a request fires on val&rdy at a rising edge
- dmem_req_op  in  4  0000 load, 0001 store, 0100 amo_add, 0101 amo_swap; other codes reserved
- dmem_req_addr  in  32  byte address; bits [2:0] ignored
- dmem_req_data  in  64  store/AMO operand
- dmem_req_wmask  in  8  byte enables for store and AMO write-back; bit i covers data[8i+7:8i]
- dmem_req_tag  in  12  opaque tag, returned unchanged
- dmem_resp_val  out  1  response valid, one-cycle pulse per response, no back-pressure
- dmem_resp_data  out  64  full doubleword read (pre-modification value for AMOs)
- dmem_resp_tag  out  12  tag of the request being answered

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Index: idx = addr[WORDS_LOG2+2:3]. Upper address bits are ignored, so addresses alias modulo array size.
- FSM states:
  - IDLE: dmem_req_rdy=1.
  - AMO_WR: dmem_req_rdy=0.
- Load (IDLE, fire):
  - Array read at the fire edge.
  - Pushes {tag, rdata} into the response pipe.
  - Stays in IDLE.
- Store (IDLE, fire):
  - Bytes with wmask=1 written at the fire edge; other bytes unchanged.
  - No response generated. Stays in IDLE.
- AMO (IDLE, fire):
  - Fire edge: old value read; {tag, old} pushed into the response pipe; op, idx, data, wmask latched; go to AMO_WR.
  - AMO_WR: write new value under the latched wmask at the next edge, then return to IDLE.
  - amo_add: new = old + data, full 64-bit modulo-2^64 add; carries cross masked-out bytes, but only enabled bytes are stored.
  - amo_swap: new = data.
  - Net effect: an AMO blocks the port for exactly one extra cycle.
- Reserved op (IDLE, fire): accepted and consumed; no array access, no response.
- Response pipe:
  - LATENCY-stage shift register of {val, tag, data}.
  - A response fired at edge N appears with dmem_resp_val=1 in the cycle following edge N+LATENCY-1. LATENCY=1 means visible the cycle right after the fire edge.
  - One entry per cycle maximum; ordering is strictly fire order.
- Ordering: a load fired in the cycle after a store or after AMO_WR, to the same idx, returns the newly written data. The single port guarantees no same-cycle conflict.
- dmem_resp_data and dmem_resp_tag are don't-care when dmem_resp_val=0. The bench checks them only with val.
- Reset:
  - Clears all pipe valid bits (dmem_resp_val=0) and forces IDLE (dmem_req_rdy=1 the cycle after the reset edge; 0 is not required during reset).
  - An AMO in AMO_WR when reset asserts does not perform its write.
  - In-flight responses are dropped.
  - Array contents are not reset.
- dmem_req_rdy does not depend combinationally on dmem_req_val.

Test Plan:
- Store/load: store addr 0x100, data 0x1122334455667788, wmask 0xFF; then load tag 0x005 -> resp_val exactly LATENCY cycles later, data 0x1122334455667788, tag 0x005.
- Byte mask: with 0x100 holding 0x1122334455667788, store data 0xAAAAAAAAAAAAAAAA, wmask 0x0F; load -> 0x11223344AAAAAAAA.
- AMO add: word holds 0x00000000FFFFFFFF; amo_add data 1, wmask 0xFF, tag 0x7A -> response data 0x00000000FFFFFFFF tag 0x7A; req_rdy=0 for one cycle; following load -> 0x0000000100000000.
- Back-to-back: loads with tags 1,2,3 on consecutive cycles -> three consecutive resp_val pulses, tags 1,2,3 in order. Load after AMO_WR returns the post-AMO value.
- Aliasing/reserved: store to 0x100 then load from 0x100 + (8<<WORDS_LOG2) -> same data. Op 0011 -> no response, array unchanged.
- Reset mid-flight: fire load, then assert reset before the response -> no resp_val. Fire amo_swap, then assert reset in AMO_WR -> later load returns the pre-AMO value.
